// File: rtl/detector_jogada_if.sv
// detector_jogada_if: button/timeout handshake bundle between the game control unit and detector_jogada.
//   botoes          : raw asynchronous buttons, active-high (master -> slave)
//   conta_timeout   : timeout counter enable (master -> slave)
//   zera_timeout    : synchronous timeout counter clear (master -> slave)
//   tem_jogada      : one-cycle pulse per accepted press (slave -> master)
//   jogada          : accepted button pattern, held until the next press (slave -> master)
//   jogada_invalida : accepted pattern is not one-hot (slave -> master)
//   timeout         : sticky timeout flag (slave -> master)
//   db_estado       : FSM state code for debug (slave -> master)
interface detector_jogada_if;
    logic [3:0] botoes;
    logic       conta_timeout;
    logic       zera_timeout;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic       jogada_invalida;
    logic       timeout;
    logic [1:0] db_estado;
    modport master (
        output botoes, conta_timeout, zera_timeout,
        input  tem_jogada, jogada, jogada_invalida, timeout, db_estado
    );
    modport slave (
        input  botoes, conta_timeout, zera_timeout,
        output tem_jogada, jogada, jogada_invalida, timeout, db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// detector_jogada: synchronizes and debounces the buttons, emits one jogada per press and runs the play timeout.
//   clock : rising-edge system clock
//   reset : synchronous, active-low; clears all state
//   bus   : detector_jogada_if.slave (buttons and timeout controls in, play code/pulse/timeout out)
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TIMEOUT_CICLOS  = 5000
) (
    input logic         clock,
    input logic         reset,
    detector_jogada_if.slave bus
);
    typedef enum logic [1:0] {
        REPOUSO        = 2'b00,
        DETECTA        = 2'b01,
        AGUARDA_SOLTAR = 2'b10
    } estado_t;

    localparam logic [7:0]  DB_MAX = 8'(DEBOUNCE_CICLOS - 1);
    localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CICLOS - 1);

    logic [3:0]  s1, s2, candidato, estavel, jogada;
    logic [7:0]  cnt;
    logic [15:0] cnt_to;
    logic        jogada_invalida, timeout, entra;
    estado_t     estado, proximo;

    // a value is accepted only after it has been seen unchanged for DEBOUNCE_CICLOS comparisons
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            candidato <= '0;
            cnt       <= '0;
            estavel   <= '0;
        end else begin
            s1 <= bus.botoes;
            s2 <= s1;
            if (s2 != candidato) begin
                candidato <= s2;
                cnt       <= '0;
            end else if (cnt < DB_MAX) begin
                cnt <= cnt + 8'd1;
            end else begin
                estavel <= candidato;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) estado <= REPOUSO;
        else        estado <= proximo;
    end

    // the unused code 11 falls through to REPOUSO
    always_comb begin
        entra   = (estado == REPOUSO) && (estavel != 4'b0000);
        proximo = entra                                                ? DETECTA :
                  (estado == DETECTA)                                  ? AGUARDA_SOLTAR :
                  (estado == AGUARDA_SOLTAR && estavel != 4'b0000)     ? AGUARDA_SOLTAR :
                                                                         REPOUSO;
    end

    // clear beats a press, a press beats counting; the counter saturates once the flag is set
    always_ff @(posedge clock) begin
        if (!reset) begin
            jogada          <= '0;
            jogada_invalida <= 1'b0;
            cnt_to          <= '0;
            timeout         <= 1'b0;
        end else begin
            if (entra) begin
                jogada          <= estavel;
                jogada_invalida <= ($countones(estavel) != 1);
            end
            if (bus.zera_timeout || entra) begin
                cnt_to  <= '0;
                timeout <= 1'b0;
            end else if (bus.conta_timeout && estado == REPOUSO) begin
                if (cnt_to == TO_MAX) timeout <= 1'b1;
                else                  cnt_to  <= cnt_to + 16'd1;
            end
        end
    end

    assign bus.tem_jogada      = (estado == DETECTA);
    assign bus.jogada          = jogada;
    assign bus.jogada_invalida = jogada_invalida;
    assign bus.timeout         = timeout;
    assign bus.db_estado       = estado;
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed stimulus with a cycle-level reference model and literal latency/value checks.
module tb_detector_jogada;
    localparam int D = 4;
    localparam int T = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    detector_jogada_if bus();

    detector_jogada #(.DEBOUNCE_CICLOS(D), .TIMEOUT_CICLOS(T)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int ciclo   = 0;
    int npulsos = 0;
    bit chk     = 1'b0;

    // reference model: sample history, run length of the synchronized value, phase, cycles counted
    logic [3:0] h1 = '0, h2 = '0, rv = '0, est = '0, jog = '0, vis;
    int         rl = 1, tc = 0;
    logic [1:0] fase = 2'd0;
    logic       inv = 1'b0, tflag = 1'b0, entra_m;

    always @(posedge clk) begin
        ciclo++;
        if (!rst_n) begin
            h1 = '0; h2 = '0; rv = '0; rl = 1; est = '0;
            fase = 2'd0; jog = '0; inv = 1'b0; tc = 0; tflag = 1'b0;
        end else begin
            entra_m = (fase == 2'd0) && (est != 4'b0000);
            if (bus.zera_timeout || entra_m) begin
                tc = 0;
                tflag = 1'b0;
            end else if (bus.conta_timeout && fase == 2'd0) begin
                tc++;
                if (tc >= T) tflag = 1'b1;
            end
            if (entra_m) begin
                jog = est;
                inv = ($countones(est) != 1);
            end
            fase = entra_m ? 2'd1 : (fase == 2'd1) ? 2'd2 : (fase == 2'd2 && est != 0) ? 2'd2 : 2'd0;
            vis = h2;
            h2  = h1;
            h1  = bus.botoes;
            if (vis == rv) begin
                if (rl < 1000) rl++;
            end else begin
                rv = vis;
                rl = 1;
            end
            if (rl >= D + 1) est = rv;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            vectors++;
            if ({bus.tem_jogada, bus.jogada, bus.jogada_invalida, bus.timeout, bus.db_estado} !==
                {fase == 2'd1, jog, inv, tflag, fase}) begin
                errors++;
                $display("FAIL cycle %0d: got tem=%b jog=%b inv=%b to=%b est=%b, expected tem=%b jog=%b inv=%b to=%b est=%b",
                         ciclo, bus.tem_jogada, bus.jogada, bus.jogada_invalida, bus.timeout, bus.db_estado,
                         fase == 2'd1, jog, inv, tflag, fase);
            end
            if (bus.tem_jogada === 1'b1) npulsos++;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_pulse(input int k, output int lat);
        lat = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.tem_jogada === 1'b1) begin
                lat = ciclo - k;
                break;
            end
        end
    endtask

    task automatic press(input logic [3:0] v, input string nm);
        int k, lat;
        bus.botoes = v;
        k = ciclo + 1;
        wait_pulse(k, lat);
        check(nm, lat, 7);
    endtask

    task automatic release_all();
        bus.botoes = 4'b0000;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int p0, r, s, lat;
        bus.botoes = 4'b0000;
        bus.conta_timeout = 1'b0;
        bus.zera_timeout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk = 1'b1;
        // idle after reset
        repeat (20) @(negedge clk);
        check("idle_estado", bus.db_estado, 0);
        check("idle_jogada", bus.jogada, 0);
        check("idle_tem", bus.tem_jogada, 0);
        // single one-hot press, state walk, release latency
        press(4'b0100, "lat_0100");
        check("detecta_estado", bus.db_estado, 1);
        check("jogada_0100", bus.jogada, 4'b0100);
        check("inv_0100", bus.jogada_invalida, 0);
        @(negedge clk);
        check("aguarda_estado", bus.db_estado, 2);
        repeat (3) @(negedge clk);
        bus.botoes = 4'b0000;
        r = ciclo + 1;
        lat = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.db_estado == 2'd0) begin
                lat = ciclo - r;
                break;
            end
        end
        check("release_lat", lat, 7);
        repeat (5) @(negedge clk);
        // glitch rejected, then a two-button press
        p0 = npulsos;
        bus.botoes = 4'b0001;
        repeat (3) @(negedge clk);
        bus.botoes = 4'b0000;
        repeat (12) @(negedge clk);
        check("glitch_pulses", npulsos - p0, 0);
        check("glitch_jogada", bus.jogada, 4'b0100);
        press(4'b0011, "lat_0011");
        check("jogada_0011", bus.jogada, 4'b0011);
        check("inv_0011", bus.jogada_invalida, 1);
        repeat (4) @(negedge clk);
        release_all();
        // extra button added while held
        p0 = npulsos;
        press(4'b1000, "lat_1000");
        repeat (2) @(negedge clk);
        bus.botoes = 4'b1001;
        repeat (15) @(negedge clk);
        check("hold_pulses", npulsos - p0, 1);
        check("hold_jogada", bus.jogada, 4'b1000);
        release_all();
        // timeout rises after T counted edges and is sticky
        bus.zera_timeout = 1'b1;
        @(negedge clk);
        bus.zera_timeout = 1'b0;
        bus.conta_timeout = 1'b1;
        s = ciclo + 1;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.timeout === 1'b1) begin
                lat = ciclo - s + 1;
                break;
            end
        end
        check("timeout_edges", lat, 20);
        repeat (5) @(negedge clk);
        check("timeout_sticky", bus.timeout, 1);
        // clear and press landing on the same edge
        bus.botoes = 4'b0010;
        repeat (7) @(negedge clk);
        bus.zera_timeout = 1'b1;
        @(negedge clk);
        bus.zera_timeout = 1'b0;
        check("zera_press_tem", bus.tem_jogada, 1);
        check("zera_press_to", bus.timeout, 0);
        check("zera_press_jog", bus.jogada, 4'b0010);
        repeat (3) @(negedge clk);
        release_all();
        check("recount_to", bus.timeout, 0);
        bus.conta_timeout = 1'b0;
        bus.zera_timeout = 1'b1;
        @(negedge clk);
        bus.zera_timeout = 1'b0;
        // reset while waiting for release, button still held
        press(4'b0100, "lat_pre_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_estado", bus.db_estado, 0);
        check("rst_jogada", bus.jogada, 0);
        check("rst_tem", bus.tem_jogada, 0);
        rst_n = 1'b1;
        s = ciclo + 1;
        wait_pulse(s, lat);
        check("lat_post_reset", lat, 7);
        check("jogada_post_reset", bus.jogada, 4'b0100);
        repeat (3) @(negedge clk);
        release_all();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
